// File: rtl/fpg8_pkg.sv
// Shared encodings and widths for the GPR file and its transfer sequencer.
package fpg8_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [1:0] {
    OP_MOV  = 2'b00,
    OP_LDI  = 2'b01,
    OP_SWAP = 2'b10,
    OP_READ = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_B = 3'd4
  } xfer_state_e;

endpackage

// File: rtl/gpr_xfer_ctrl.sv
// Turns MOV/LDI/SWAP/READ requests into single-register GPR bus cycles.
// All outputs are registered; they are decoded from the next state and next captured fields.
module gpr_xfer_ctrl #(
  parameter int unsigned DATA_W = fpg8_pkg::DATA_W,
  parameter int unsigned SEL_W  = fpg8_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [SEL_W-1:0]  req_rd,
  input  logic [SEL_W-1:0]  req_rs,
  input  logic [DATA_W-1:0] req_imm,
  output logic              done,
  output logic [DATA_W-1:0] rsp_data,
  output logic              GPR_in,
  output logic              GPR_out,
  output logic [SEL_W-1:0]  GPR_select,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive
);
  import fpg8_pkg::*;

  xfer_state_e       state_q, state_d;
  op_e               op_q, op_d;
  logic [SEL_W-1:0]  rd_q, rd_d, rs_q, rs_d;
  logic [DATA_W-1:0] imm_q, imm_d, tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d;
  logic [DATA_W-1:0] rsp_q, rsp_d, bus_out_q, bus_out_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              done_q, done_d, ready_q, ready_d;
  logic              gpr_in_q, gpr_in_d, gpr_out_q, gpr_out_d, drive_q, drive_d;

  // Next-state, capture and temp-register update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    imm_d   = imm_q;
    tmp_a_d = tmp_a_q;
    tmp_b_d = tmp_b_q;
    rsp_d   = rsp_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = op_e'(req_op);
          rd_d    = req_rd;
          rs_d    = req_rs;
          imm_d   = req_imm;
          state_d = (op_e'(req_op) == OP_LDI) ? ST_WR_A : ST_RD_A;
        end
      end
      ST_RD_A: begin
        tmp_a_d = bus_in;
        if (op_q == OP_READ) begin
          rsp_d   = bus_in;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (op_q == OP_SWAP) begin
          state_d = ST_RD_B;
        end else begin
          state_d = ST_WR_A;
        end
      end
      ST_RD_B: begin
        tmp_b_d = bus_in;
        state_d = ST_WR_A;
      end
      ST_WR_A: begin
        if (op_q == OP_SWAP) begin
          state_d = ST_WR_B;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_B: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe decode for the cycle the FSM is about to enter; IDLE keeps everything low
  always_comb begin
    gpr_in_d  = 1'b0;
    gpr_out_d = 1'b0;
    drive_d   = 1'b0;
    sel_d     = '0;
    bus_out_d = '0;
    ready_d   = (state_d == ST_IDLE);
    unique case (state_d)
      ST_RD_A: begin
        gpr_out_d = 1'b1;
        sel_d     = (op_d == OP_SWAP) ? rd_d : rs_d;
      end
      ST_RD_B: begin
        gpr_out_d = 1'b1;
        sel_d     = rs_d;
      end
      ST_WR_A: begin
        gpr_in_d  = 1'b1;
        drive_d   = 1'b1;
        sel_d     = rd_d;
        bus_out_d = (op_d == OP_LDI)  ? imm_d :
                    (op_d == OP_SWAP) ? tmp_b_d : tmp_a_d;
      end
      ST_WR_B: begin
        gpr_in_d  = 1'b1;
        drive_d   = 1'b1;
        sel_d     = rs_d;
        bus_out_d = tmp_a_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MOV;
      rd_q      <= '0;
      rs_q      <= '0;
      imm_q     <= '0;
      tmp_a_q   <= '0;
      tmp_b_q   <= '0;
      rsp_q     <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      gpr_in_q  <= 1'b0;
      gpr_out_q <= 1'b0;
      drive_q   <= 1'b0;
      sel_q     <= '0;
      bus_out_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      imm_q     <= imm_d;
      tmp_a_q   <= tmp_a_d;
      tmp_b_q   <= tmp_b_d;
      rsp_q     <= rsp_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      gpr_in_q  <= gpr_in_d;
      gpr_out_q <= gpr_out_d;
      drive_q   <= drive_d;
      sel_q     <= sel_d;
      bus_out_q <= bus_out_d;
    end
  end

  assign req_ready  = ready_q;
  assign done       = done_q;
  assign rsp_data   = rsp_q;
  assign GPR_in     = gpr_in_q;
  assign GPR_out    = gpr_out_q;
  assign GPR_select = sel_q;
  assign bus_out    = bus_out_q;
  assign bus_drive  = drive_q;

endmodule

// File: tb/tb_gpr_xfer_ctrl.sv
// Directed bench for gpr_xfer_ctrl with a behavioural 8-entry GPR file on the bus.
module tb_gpr_xfer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [2:0]  req_rd, req_rs;
  logic [15:0] req_imm;
  logic        done;
  logic [15:0] rsp_data;
  logic        GPR_in, GPR_out;
  logic [2:0]  GPR_select;
  logic [15:0] bus_in, bus_out;
  logic        bus_drive;

  logic [15:0] regs [8];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpr_xfer_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs(req_rs), .req_imm(req_imm),
    .done(done), .rsp_data(rsp_data),
    .GPR_in(GPR_in), .GPR_out(GPR_out), .GPR_select(GPR_select),
    .bus_in(bus_in), .bus_out(bus_out), .bus_drive(bus_drive)
  );

  // GPR file: drives the selected register on GPR_out, latches the bus on GPR_in
  assign bus_in = bus_drive ? bus_out : (GPR_out ? regs[GPR_select] : 16'h0000);
  always @(posedge clk) if (GPR_in) regs[GPR_select] <= bus_in;

  always @(negedge clk) begin
    checks++;
    if (GPR_out && bus_drive) begin
      errors++; $display("FAIL inv_out_drive: GPR_out=%b bus_drive=%b", GPR_out, bus_drive);
    end
    checks++;
    if (GPR_in && GPR_out) begin
      errors++; $display("FAIL inv_in_out: GPR_in=%b GPR_out=%b", GPR_in, GPR_out);
    end
    checks++;
    if (req_ready && (GPR_in || GPR_out || bus_drive)) begin
      errors++; $display("FAIL inv_idle_strobes: in=%b out=%b drive=%b", GPR_in, GPR_out, bus_drive);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a request now; returns #1 into the first cycle after the accept edge
  task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [15:0] imm);
    req_valid = 1'b1; req_op = op; req_rd = rd; req_rs = rs; req_imm = imm;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_rd = 3'd0; req_rs = 3'd0; req_imm = 16'h0;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0;
    #12;
    checks++;
    if ({GPR_in, GPR_out, bus_drive, done} !== 4'b0000 || GPR_select !== 3'd0 || bus_out !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: in/out/drv/done=%b sel=%0d bus=%h required 0", {GPR_in, GPR_out, bus_drive, done}, GPR_select, bus_out);
    end
    checks++;
    if (req_ready !== 1'b1 || rsp_data !== 16'h0) begin
      errors++; $display("FAIL reset_ready_rsp: ready=%b rsp=%h required 1/0000", req_ready, rsp_data);
    end
    @(negedge clk); reset = 1'b1;
    step();
  endtask

  task automatic test_mov();
    regs[5] = 16'h1234;
    issue(2'b00, 3'd3, 3'd5, 16'h0);
    checks++;
    if ({GPR_out, GPR_in, bus_drive} !== 3'b100 || GPR_select !== 3'd5 || req_ready !== 1'b0) begin
      errors++; $display("FAIL mov_rd_a: out/in/drv=%b sel=%0d ready=%b required 100/5/0", {GPR_out, GPR_in, bus_drive}, GPR_select, req_ready);
    end
    step();
    checks++;
    if ({GPR_out, GPR_in, bus_drive} !== 3'b011 || GPR_select !== 3'd3 || bus_out !== 16'h1234) begin
      errors++; $display("FAIL mov_wr_a: out/in/drv=%b sel=%0d bus=%h required 011/3/1234", {GPR_out, GPR_in, bus_drive}, GPR_select, bus_out);
    end
    step();
    checks++;
    if (done !== 1'b1 || req_ready !== 1'b1 || regs[3] !== 16'h1234) begin
      errors++; $display("FAIL mov_done: done=%b ready=%b R3=%h required 1/1/1234", done, req_ready, regs[3]);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL mov_done_pulse: done=%b required 0", done);
    end
  endtask

  task automatic test_ldi();
    issue(2'b01, 3'd2, 3'd0, 16'hAAAA);
    checks++;
    if ({GPR_out, GPR_in, bus_drive} !== 3'b011 || GPR_select !== 3'd2 || bus_out !== 16'hAAAA || done !== 1'b0) begin
      errors++; $display("FAIL ldi_wr_a: out/in/drv=%b sel=%0d bus=%h done=%b required 011/2/aaaa/0", {GPR_out, GPR_in, bus_drive}, GPR_select, bus_out, done);
    end
    step();
    checks++;
    if (done !== 1'b1 || regs[2] !== 16'hAAAA) begin
      errors++; $display("FAIL ldi_done: done=%b R2=%h required 1/aaaa", done, regs[2]);
    end
    step();
  endtask

  task automatic test_swap();
    logic [2:0]  exp_sel [4] = '{3'd1, 3'd6, 3'd1, 3'd6};
    logic [1:0]  exp_str [4] = '{2'b10, 2'b10, 2'b01, 2'b01};
    logic [15:0] exp_bus [4] = '{16'h0001, 16'h0006, 16'h0006, 16'h0001};
    regs[1] = 16'h0001; regs[6] = 16'h0006;
    issue(2'b10, 3'd1, 3'd6, 16'h0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (GPR_select !== exp_sel[i] || {GPR_out, GPR_in} !== exp_str[i] || bus_in !== exp_bus[i] || done !== 1'b0) begin
        errors++; $display("FAIL swap_cycle%0d: sel=%0d out/in=%b bus=%h done=%b required %0d/%b/%h/0", i, GPR_select, {GPR_out, GPR_in}, bus_in, done, exp_sel[i], exp_str[i], exp_bus[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || regs[1] !== 16'h0006 || regs[6] !== 16'h0001) begin
      errors++; $display("FAIL swap_done: done=%b R1=%h R6=%h required 1/0006/0001", done, regs[1], regs[6]);
    end
    step();
  endtask

  task automatic test_read();
    regs[7] = 16'hBEEF;
    issue(2'b11, 3'd0, 3'd7, 16'h0);
    checks++;
    if ({GPR_out, GPR_in} !== 2'b10 || GPR_select !== 3'd7) begin
      errors++; $display("FAIL read_rd_a: out/in=%b sel=%0d required 10/7", {GPR_out, GPR_in}, GPR_select);
    end
    step();
    checks++;
    if (done !== 1'b1 || rsp_data !== 16'hBEEF || GPR_in !== 1'b0) begin
      errors++; $display("FAIL read_done: done=%b rsp=%h GPR_in=%b required 1/beef/0", done, rsp_data, GPR_in);
    end
    step();
    checks++;
    if (done !== 1'b0 || rsp_data !== 16'hBEEF) begin
      errors++; $display("FAIL read_hold: done=%b rsp=%h required 0/beef", done, rsp_data);
    end
  endtask

  task automatic test_reset_mid();
    int seen_done = 0;
    regs[1] = 16'h1111; regs[6] = 16'h6666;
    issue(2'b10, 3'd1, 3'd6, 16'h0);
    step();
    checks++;
    if (GPR_select !== 3'd6 || GPR_out !== 1'b1) begin
      errors++; $display("FAIL rst_mid_rd_b: sel=%0d out=%b required 6/1", GPR_select, GPR_out);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({GPR_in, GPR_out, bus_drive, done} !== 4'b0000 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_strobes: in/out/drv/done=%b ready=%b required 0000/1", {GPR_in, GPR_out, bus_drive, done}, req_ready);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) seen_done++;
      step();
    end
    checks++;
    if (seen_done != 0 || regs[1] !== 16'h1111 || regs[6] !== 16'h6666) begin
      errors++; $display("FAIL rst_mid_after: done_pulses=%0d R1=%h R6=%h required 0/1111/6666", seen_done, regs[1], regs[6]);
    end
  endtask

  task automatic test_busy();
    logic [2:0] exp_sel [4] = '{3'd2, 3'd4, 3'd2, 3'd4};
    regs[2] = 16'h2222; regs[4] = 16'h4444; regs[0] = 16'h0000;
    issue(2'b10, 3'd2, 3'd4, 16'h0);
    req_valid = 1'b1; req_op = 2'b01; req_rd = 3'd0; req_rs = 3'd0; req_imm = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_ready !== 1'b0 || GPR_select !== exp_sel[i] || (i < 2 && GPR_out !== 1'b1) || (i >= 2 && GPR_in !== 1'b1)) begin
        errors++; $display("FAIL busy_cycle%0d: ready=%b sel=%0d out=%b in=%b required 0/%0d", i, req_ready, GPR_select, GPR_out, GPR_in, exp_sel[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || req_ready !== 1'b1 || regs[2] !== 16'h4444 || regs[4] !== 16'h2222 || regs[0] !== 16'h0000) begin
      errors++; $display("FAIL busy_done: done=%b ready=%b R2=%h R4=%h R0=%h required 1/1/4444/2222/0000", done, req_ready, regs[2], regs[4], regs[0]);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (GPR_in !== 1'b1 || GPR_select !== 3'd0 || bus_out !== 16'hFFFF) begin
      errors++; $display("FAIL busy_held_ldi: in=%b sel=%0d bus=%h required 1/0/ffff", GPR_in, GPR_select, bus_out);
    end
    step();
    checks++;
    if (done !== 1'b1 || regs[0] !== 16'hFFFF) begin
      errors++; $display("FAIL busy_held_done: done=%b R0=%h required 1/ffff", done, regs[0]);
    end
    step();
  endtask

  task automatic test_back_to_back();
    issue(2'b01, 3'd4, 3'd0, 16'h5A5A);
    step();
    checks++;
    if (done !== 1'b1 || req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ldi_done: done=%b ready=%b required 1/1", done, req_ready);
    end
    issue(2'b00, 3'd1, 3'd4, 16'h0);
    checks++;
    if (GPR_out !== 1'b1 || GPR_select !== 3'd4 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_mov_rd_a: out=%b sel=%0d done=%b required 1/4/0", GPR_out, GPR_select, done);
    end
    step();
    checks++;
    if (GPR_in !== 1'b1 || GPR_select !== 3'd1 || bus_out !== 16'h5A5A) begin
      errors++; $display("FAIL b2b_mov_wr_a: in=%b sel=%0d bus=%h required 1/1/5a5a", GPR_in, GPR_select, bus_out);
    end
    step();
    checks++;
    if (done !== 1'b1 || regs[1] !== 16'h5A5A || regs[4] !== 16'h5A5A) begin
      errors++; $display("FAIL b2b_mov_done: done=%b R1=%h R4=%h required 1/5a5a/5a5a", done, regs[1], regs[4]);
    end
    step();
  endtask

  task automatic test_same_reg();
    int cycles = 0;
    regs[0] = 16'hC0DE;
    issue(2'b10, 3'd0, 3'd0, 16'h0);
    while (done !== 1'b1 && cycles < 10) begin
      step(); cycles++;
    end
    checks++;
    if (cycles != 4 || regs[0] !== 16'hC0DE) begin
      errors++; $display("FAIL swap_same: cycles=%0d R0=%h required 4/c0de", cycles, regs[0]);
    end
    step();
    issue(2'b00, 3'd0, 3'd0, 16'h0);
    step(); step();
    checks++;
    if (done !== 1'b1 || regs[0] !== 16'hC0DE) begin
      errors++; $display("FAIL mov_same: done=%b R0=%h required 1/c0de", done, regs[0]);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_mov();
    test_ldi();
    test_swap();
    test_read();
    test_reset_mid();
    test_busy();
    test_back_to_back();
    test_same_reg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
